// File: rtl/sign_logger_pkg.sv
// Shared types and constants for the multi-channel signature logger.
package sign_logger_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        LOG  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        ONESHOT  = 1'b0,
        CIRCULAR = 1'b1
    } mode_e;

    localparam int DROP_W = 16;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

endpackage

// File: rtl/sign_logger_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts just after the last grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_req,
    input  logic         i_upd,
    output logic [N-1:0] o_gnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_hi_idx;
    logic [IW-1:0] w_lo_idx;
    logic [IW-1:0] w_gnt_idx;
    logic [IW-1:0] w_ptr_next;
    logic          w_hi_found;
    logic          w_lo_found;

    // Search channels at/after the pointer first, then wrap to the lowest requester.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (i_req[i] && !w_hi_found && (IW'(i) >= r_ptr)) begin
                w_hi_found = 1'b1;
                w_hi_idx   = IW'(i);
            end
            if (i_req[i] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_idx   = IW'(i);
            end
        end
        w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    assign o_gnt      = (|i_req) ? (N'(1) << w_gnt_idx) : '0;
    assign w_ptr_next = (w_gnt_idx == LAST) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_upd && (|i_req)) begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/sign_logger.sv
// Multi-channel signature logger: decimated per-channel capture into hold registers,
// round-robin drained into a single-port SRAM, with an external scan-out override.
module sign_logger
    import sign_logger_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int NUM_CH  = 4,
    parameter int DECIM_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_mode,
    input  logic [DECIM_W-1:0]       i_decim,
    input  logic [NUM_CH-1:0]        i_ch_mask,
    input  logic [NUM_CH-1:0]        i_ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
    input  logic                     i_ext_en,
    input  logic                     i_ext_cen,
    input  logic                     i_ext_wen,
    input  logic [ADDR_W-1:0]        i_ext_addr,
    input  logic [DATA_W-1:0]        i_ext_wdata,
    output logic [DATA_W-1:0]        o_ext_rdata,
    output logic                     o_mem_cen,
    output logic                     o_mem_wen,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [DATA_W-1:0]        o_mem_wdata,
    input  logic [DATA_W-1:0]        i_mem_rdata,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_wrapped,
    output logic [ADDR_W-1:0]        o_wr_ptr,
    output logic [DROP_W-1:0]        o_drop_cnt,
    output logic [1:0]               o_dbg_state
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DSUM_W = CH_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e              r_state;
    state_e              w_next_state;
    logic [NUM_CH-1:0]   r_mask;
    mode_e               r_mode;
    logic [DECIM_W-1:0]  r_decim;
    logic [DECIM_W-1:0]  r_dcnt [NUM_CH];
    logic [DATA_W-1:0]   r_hold [NUM_CH];
    logic [NUM_CH-1:0]   r_full;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic                r_wrapped;
    logic [DROP_W-1:0]   r_drop_cnt;
    logic                r_ext_rd;

    logic                w_start_ok;
    logic                w_log;
    logic                w_capture;
    logic                w_wr_allow;
    logic                w_wr;
    logic                w_final;
    logic [NUM_CH-1:0]   w_sample;
    logic [NUM_CH-1:0]   w_keep;
    logic [NUM_CH-1:0]   w_drop;
    logic [NUM_CH-1:0]   w_req;
    logic [NUM_CH-1:0]   w_gnt;
    logic [DSUM_W-1:0]   w_drop_sum;
    logic [DATA_W-1:0]   w_gnt_data;
    logic [DROP_W:0]     w_drop_add;
    logic [DROP_W-1:0]   w_drop_next;

    assign w_start_ok = i_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_log      = (r_state == LOG);
    assign w_capture  = w_log && !i_stop;
    assign w_wr_allow = w_capture && !i_ext_en;
    assign w_req      = r_full & {NUM_CH{w_wr_allow}};
    assign w_wr       = |w_gnt;
    assign w_final    = w_wr && (r_mode == ONESHOT) && (r_wr_ptr == LAST_ADDR);

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_req   (w_req),
        .i_upd   (w_wr_allow),
        .o_gnt   (w_gnt)
    );

    always_comb begin
        w_sample = '0;
        w_keep   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_sample[c] = w_capture && r_mask[c] && i_ch_valid[c];
            w_keep[c]   = w_capture && r_mask[c] && i_ch_valid[c] && (r_dcnt[c] == '0);
        end
    end

    // A kept sample is lost only if its hold register is full and not being drained now.
    always_comb begin
        w_drop     = w_keep & r_full & ~w_gnt;
        w_drop_sum = '0;
        w_gnt_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_drop_sum = w_drop_sum + DSUM_W'(w_drop[c]);
            w_gnt_data = w_gnt_data | (r_hold[c] & {DATA_W{w_gnt[c]}});
        end
    end

    assign w_drop_add  = {1'b0, r_drop_cnt} + (DROP_W + 1)'(w_drop_sum);
    assign w_drop_next = w_drop_add[DROP_W] ? DROP_MAX : w_drop_add[DROP_W-1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = ARM;
            ARM:     w_next_state = LOG;
            LOG:     if (i_stop || w_final) w_next_state = DONE;
            DONE:    if (i_start) w_next_state = ARM;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (r_state == ARM) || (r_state == LOG);
        o_done      = (r_state == DONE);
        o_dbg_state = r_state;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_full <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_dcnt[c] <= '0;
                r_hold[c] <= '0;
            end
        end else if (r_state == ARM) begin
            r_full <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_dcnt[c] <= '0;
                r_hold[c] <= '0;
            end
        end else begin
            if (w_log && i_stop) begin
                r_full <= '0;
            end else begin
                r_full <= (r_full & ~w_gnt) | w_keep;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_sample[c]) begin
                    r_dcnt[c] <= (r_dcnt[c] == r_decim) ? '0 : r_dcnt[c] + 1'b1;
                end
                if (w_keep[c] && !w_drop[c]) begin
                    r_hold[c] <= i_ch_data[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mask     <= '0;
            r_mode     <= ONESHOT;
            r_decim    <= '0;
            r_wr_ptr   <= '0;
            r_wrapped  <= 1'b0;
            r_drop_cnt <= '0;
            r_ext_rd   <= 1'b0;
        end else begin
            r_ext_rd <= i_ext_en && !i_ext_cen && i_ext_wen;
            if (w_start_ok) begin
                r_mask  <= i_ch_mask;
                r_mode  <= mode_e'(i_mode);
                r_decim <= i_decim;
            end
            if (r_state == ARM) begin
                r_wr_ptr   <= '0;
                r_wrapped  <= 1'b0;
                r_drop_cnt <= '0;
            end else begin
                r_drop_cnt <= w_drop_next;
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if ((r_wr_ptr == LAST_ADDR) && (r_mode == CIRCULAR)) begin
                        r_wrapped <= 1'b1;
                    end
                end
            end
        end
    end

    // External port owns the SRAM pins whenever enabled, regardless of state.
    always_comb begin
        o_mem_cen   = 1'b1;
        o_mem_wen   = 1'b1;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (i_ext_en) begin
            o_mem_cen   = i_ext_cen;
            o_mem_wen   = i_ext_wen;
            o_mem_addr  = i_ext_addr;
            o_mem_wdata = i_ext_wdata;
        end else if (w_wr) begin
            o_mem_cen   = 1'b0;
            o_mem_wen   = 1'b0;
            o_mem_addr  = r_wr_ptr;
            o_mem_wdata = w_gnt_data;
        end
    end

    assign o_ext_rdata = r_ext_rd ? i_mem_rdata : '0;
    assign o_wrapped   = r_wrapped;
    assign o_wr_ptr    = r_wr_ptr;
    assign o_drop_cnt  = r_drop_cnt;

endmodule
